// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file: read ports, issue
// request, writeback triple and the stall/err status returned to decode.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] read1reg;
    logic [ADDR_W-1:0] read2reg;
    logic              read1_en;
    logic              read2_en;
    logic [DATA_W-1:0] read1data;
    logic [DATA_W-1:0] read2data;
    logic              issue_valid;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_dst;
    logic              write;
    logic [ADDR_W-1:0] writereg;
    logic [DATA_W-1:0] writedata;
    logic              stall;
    logic              err;

    modport master (
        output read1reg, read2reg, read1_en, read2_en,
        output issue_valid, issue_wr, issue_dst,
        output write, writereg, writedata,
        input  read1data, read2data, stall, err
    );

    modport slave (
        input  read1reg, read2reg, read1_en, read2_en,
        input  issue_valid, issue_wr, issue_dst,
        input  write, writereg, writedata,
        output read1data, read2data, stall, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and a per-register
// pending-writer scoreboard that stalls decode on unresolved RAW hazards.
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int PEND_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  rf
);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              err_q;
    logic              err_d;
    logic              haz1;
    logic              haz2;
    logic              stall;

    // A same-cycle writeback only resolves the hazard if it is the last
    // outstanding producer of that register.
    function automatic logic hazard(input logic en, input logic [ADDR_W-1:0] idx,
                                    input logic [PEND_W-1:0] pend,
                                    input logic wr, input logic [ADDR_W-1:0] wreg);
        logic last_dec;
        last_dec = wr && (wreg == idx) && (pend == PEND_W'(1));
        return en && (pend != '0) && !last_dec;
    endfunction

    always_comb begin
        rf.read1data = regs_q[rf.read1reg];
        rf.read2data = regs_q[rf.read2reg];
        if (rf.write && rf.writereg == rf.read1reg) rf.read1data = rf.writedata;
        if (rf.write && rf.writereg == rf.read2reg) rf.read2data = rf.writedata;
    end

    always_comb begin
        haz1  = hazard(rf.read1_en, rf.read1reg, pend_q[rf.read1reg], rf.write, rf.writereg);
        haz2  = hazard(rf.read2_en, rf.read2reg, pend_q[rf.read2reg], rf.write, rf.writereg);
        stall = rf.issue_valid && (haz1 || haz2);
    end

    assign rf.stall = stall;
    assign rf.err   = err_q;

    always_comb begin
        logic inc;
        logic dec;
        regs_d = regs_q;
        pend_d = pend_q;
        err_d  = err_q;
        inc    = 1'b0;
        dec    = 1'b0;
        if (rf.write) regs_d[rf.writereg] = rf.writedata;
        for (int i = 0; i < NREG; i++) begin
            // Stalled issues never count, so dst==src cannot lock itself out.
            inc = rf.issue_valid && rf.issue_wr && !stall && (rf.issue_dst == ADDR_W'(i));
            dec = rf.write && (rf.writereg == ADDR_W'(i));
            if (inc && !dec) begin
                if (pend_q[i] == PEND_MAX) err_d = 1'b1;
                else                       pend_d[i] = pend_q[i] + PEND_W'(1);
            end else if (dec && !inc) begin
                if (pend_q[i] == '0) err_d = 1'b1;
                else                 pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass reads, scoreboard stalls,
// counter saturation/underflow errors and mid-run reset.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) rf ();

    regfile_scoreboard #(.DATA_W(16), .NREG(8), .ADDR_W(3), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.read1reg    = '0;
        rf.read2reg    = '0;
        rf.read1_en    = 1'b0;
        rf.read2_en    = 1'b0;
        rf.issue_valid = 1'b0;
        rf.issue_wr    = 1'b0;
        rf.issue_dst   = '0;
        rf.write       = 1'b0;
        rf.writereg    = '0;
        rf.writedata   = '0;
    endtask

    task automatic issue(input logic [2:0] dst);
        idle();
        rf.issue_valid = 1'b1;
        rf.issue_wr    = 1'b1;
        rf.issue_dst   = dst;
        #1;
        chk("issue_nostall", rf.stall, 1'b0);
        tick();
    endtask

    // Decode reads src on port 1 without writing; returns the stall level.
    task automatic probe1(input logic [2:0] src);
        idle();
        rf.issue_valid = 1'b1;
        rf.read1reg    = src;
        rf.read1_en    = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        // 1: reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rf.read1reg = 3'(r);
            rf.read2reg = 3'(7 - r);
            #1;
            chk("rst_read1", rf.read1data, 16'h0000);
            chk("rst_read2", rf.read2data, 16'h0000);
        end
        probe1(3'd0);
        chk("rst_stall", rf.stall, 1'b0);
        chk("rst_err", rf.err, 1'b0);

        // 2: write-through bypass then stored value
        issue(3'd3);
        idle();
        rf.write = 1'b1; rf.writereg = 3'd3; rf.writedata = 16'hBEEF;
        rf.read1reg = 3'd3;
        #1;
        chk("bypass_r1", rf.read1data, 16'hBEEF);
        tick();
        rf.write = 1'b0;
        #1;
        chk("stored_r1", rf.read1data, 16'hBEEF);
        chk("no_err_t2", rf.err, 1'b0);

        // 3: single producer stall and release; stalled dst==src issue not counted
        issue(3'd2);
        idle();
        rf.issue_valid = 1'b1; rf.issue_wr = 1'b1; rf.issue_dst = 3'd2;
        rf.read2reg = 3'd2;
        #1;
        chk("en_off_nostall", rf.stall, 1'b0);
        rf.read2_en = 1'b1;
        #1;
        chk("raw_stall", rf.stall, 1'b1);
        tick();
        rf.issue_wr = 1'b0;
        rf.write = 1'b1; rf.writereg = 3'd2; rf.writedata = 16'h1234;
        #1;
        chk("wb_release", rf.stall, 1'b0);
        chk("wb_data_r2", rf.read2data, 16'h1234);
        tick();
        rf.write = 1'b0;
        #1;
        chk("no_selflock", rf.stall, 1'b0);
        chk("no_err_t3", rf.err, 1'b0);

        // 4: two producers, first writeback does not release
        issue(3'd5);
        issue(3'd5);
        probe1(3'd5);
        rf.read2reg = 3'd5; rf.read2_en = 1'b1;
        rf.write = 1'b1; rf.writereg = 3'd5; rf.writedata = 16'h0001;
        #1;
        chk("two_pend_stall", rf.stall, 1'b1);
        chk("two_pend_data", rf.read1data, 16'h0001);
        chk("same_port_data", rf.read2data, 16'h0001);
        tick();
        rf.writedata = 16'h0002;
        #1;
        chk("last_wb_release", rf.stall, 1'b0);
        chk("last_wb_data", rf.read1data, 16'h0002);
        tick();
        idle();
        #1;
        chk("no_err_t4", rf.err, 1'b0);

        // 5: underflow write still lands, err sticky
        rf.write = 1'b1; rf.writereg = 3'd4; rf.writedata = 16'h00AA;
        tick();
        idle();
        rf.read1reg = 3'd4;
        #1;
        chk("underflow_err", rf.err, 1'b1);
        chk("underflow_wr", rf.read1data, 16'h00AA);
        probe1(3'd4);
        chk("underflow_cnt0", rf.stall, 1'b0);
        tick();
        tick();
        chk("err_sticky", rf.err, 1'b1);

        // 6: simultaneous inc/dec keeps count, then overflow saturation
        issue(3'd6);
        idle();
        rf.issue_valid = 1'b1; rf.issue_wr = 1'b1; rf.issue_dst = 3'd6;
        rf.write = 1'b1; rf.writereg = 3'd6; rf.writedata = 16'h0066;
        tick();
        probe1(3'd6);
        chk("incdec_pend1", rf.stall, 1'b1);
        rf.write = 1'b1; rf.writereg = 3'd6; rf.writedata = 16'h0067;
        #1;
        chk("incdec_last", rf.stall, 1'b0);

        for (int k = 0; k < 4; k++) issue(3'd7);
        for (int k = 0; k < 2; k++) begin
            idle();
            rf.write = 1'b1; rf.writereg = 3'd7; rf.writedata = 16'h0077;
            tick();
        end
        probe1(3'd7);
        chk("sat_pend1", rf.stall, 1'b1);
        rf.write = 1'b1; rf.writereg = 3'd7; rf.writedata = 16'h0078;
        #1;
        chk("sat_last", rf.stall, 1'b0);

        // rst beats a concurrent write and clears the scoreboard
        idle();
        rst = 1'b1;
        rf.write = 1'b1; rf.writereg = 3'd1; rf.writedata = 16'hFFFF;
        tick();
        rst = 1'b0;
        idle();
        rf.read1reg = 3'd1; rf.read2reg = 3'd5;
        #1;
        chk("rst_drop_wr", rf.read1data, 16'h0000);
        chk("rst_clr_reg", rf.read2data, 16'h0000);
        chk("rst_clr_err", rf.err, 1'b0);
        probe1(3'd6);
        chk("rst_clr_pend6", rf.stall, 1'b0);
        probe1(3'd7);
        chk("rst_clr_pend7", rf.stall, 1'b0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end
endmodule
